systolic_seq_ctrl: RTL and testbench

//  Instruction sequencer for the 4x4 systolic array top. On ap_start, walks instruction memory (8 x 5b; value = inner dim K, 0 = end).
//  Per instruction: clears accumulators, streams pre-skewed A/B columns from memA/memB, waits for drain, then writes 16 results to output memory.

---
 rtl/systolic_pkg.sv | 41 ++++
 rtl/seq_delay_line.sv | 37 +++
 rtl/systolic_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Purpose : Shared constants and state encoding for the systolic sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int DIM          = 4;
    localparam int N_INST       = 8;
    localparam int COL_W        = 8;
    localparam int MEM_ROW_LEN  = 256;
    localparam int RES_PER_INST = DIM * DIM;
    localparam int RD_LAT       = 1;
    localparam int DRAIN        = 2;

    localparam int INST_AW  = 3;
    localparam int INST_W   = 5;
    localparam int RES_W    = 4;
    localparam int OUT_AW   = 7;
    // one extra bit so idx can reach N_INST for the terminal compare
    localparam int IDX_W    = 4;
    localparam int SPAN_W   = 9;
    localparam int SPAN_BASE = 6;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_CLEAR  = 4'd3,
        ST_STREAM = 4'd4,
        ST_DRAIN  = 4'd5,
        ST_WRITE  = 4'd6,
        ST_NEXT   = 4'd7,
        ST_DONE   = 4'd8
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_delay_line.sv
// ============================================================================
// Module  : seq_delay_line
// Purpose : DEPTH-stage single-bit shift register (aligns arr_en to read data).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= din;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= {r_sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
// ============================================================================
// Module  : systolic_seq_ctrl
// Purpose : Instruction sequencer for the 4x4 systolic array. Optional
//           busy-cycle counter enabled by SYSTOLIC_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_seq_ctrl
    import systolic_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                busy,
    output logic                err_ovf,
    output logic [INST_AW-1:0]  inst_addr,
    input  logic [INST_W-1:0]   inst_data,
    output logic [INST_W-1:0]   cur_inst,
    output logic                rd_en,
    output logic [COL_W-1:0]    rd_col,
    output logic                arr_clr,
    output logic                arr_en,
    output logic [RES_W-1:0]    res_sel,
    output logic [OUT_AW-1:0]   out_addr,
`ifdef SYSTOLIC_PERF_CNT_EN
    output logic [15:0]         perf_cycles,
`endif
    output logic                out_we
);

    seq_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
    logic [SPAN_W-1:0]   r_col,   w_col_nxt;
    logic [SPAN_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [SPAN_W-1:0]   r_span,  w_span_nxt;
    logic [INST_W-1:0]   r_cur,   w_cur_nxt;
    logic                r_err,   w_err_nxt;
    logic [SPAN_W-1:0]   w_span_dec;
    logic [SPAN_W-1:0]   w_col_end;
    logic [COL_W-1:0]    w_rd_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_span  <= '0;
            r_cur   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_col   <= w_col_nxt;
            r_cnt   <= w_cnt_nxt;
            r_span  <= w_span_nxt;
            r_cur   <= w_cur_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Non-first instructions carry one extra gap column between programs.
    assign w_span_dec = SPAN_W'(inst_data) + SPAN_W'(SPAN_BASE)
                      + ((r_idx != '0) ? SPAN_W'(1) : SPAN_W'(0));
    assign w_col_end  = r_col + w_span_dec;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        w_span_nxt  = r_span;
        w_cur_nxt   = r_cur;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = ST_FETCH;
                    w_idx_nxt   = '0;
                    w_col_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_FETCH:  w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if ((inst_data == '0) || (r_idx == IDX_W'(N_INST))) begin
                    w_state_nxt = ST_DONE;
                    w_cur_nxt   = '0;
                end else if (w_col_end > SPAN_W'(MEM_ROW_LEN)) begin
                    w_state_nxt = ST_DONE;
                    w_cur_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_CLEAR;
                    w_cur_nxt   = inst_data;
                    w_span_nxt  = w_span_dec;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_STREAM;
                w_cnt_nxt   = '0;
            end
            ST_STREAM: begin
                if (r_cnt == r_span - SPAN_W'(1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + SPAN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == SPAN_W'(RD_LAT + DRAIN - 1)) begin
                    w_state_nxt = ST_WRITE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + SPAN_W'(1);
                end
            end
            ST_WRITE: begin
                if (r_cnt == SPAN_W'(RES_PER_INST - 1)) begin
                    w_state_nxt = ST_NEXT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + SPAN_W'(1);
                end
            end
            ST_NEXT: begin
                w_state_nxt = ST_FETCH;
                w_col_nxt   = r_col + r_span;
                w_idx_nxt   = r_idx + IDX_W'(1);
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rd_col  = r_col[COL_W-1:0] + r_cnt[COL_W-1:0];

    assign ap_done   = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign err_ovf   = r_err;
    assign inst_addr = r_idx[INST_AW-1:0];
    assign cur_inst  = r_cur;
    assign rd_en     = (r_state == ST_STREAM);
    assign rd_col    = rd_en ? w_rd_col : '0;
    assign arr_clr   = (r_state == ST_CLEAR);
    assign out_we    = (r_state == ST_WRITE);
    assign res_sel   = out_we ? r_cnt[RES_W-1:0] : '0;
    assign out_addr  = out_we ? {r_idx[INST_AW-1:0], r_cnt[RES_W-1:0]} : '0;

    seq_delay_line #(
        .DEPTH (RD_LAT)
    ) u_en_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_en),
        .dout (arr_en)
    );

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [15:0] r_perf;

    // DONE is excluded so the value seen on the ap_done pulse is what holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_state == ST_IDLE) begin
            if (ap_start) r_perf <= '0;
        end else if ((r_state != ST_DONE) && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
// ============================================================================
// Module  : tb_systolic_seq_ctrl
// Purpose : Self-checking bench for systolic_seq_ctrl against a program-level
//           model. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, busy, err_ovf, rd_en, arr_clr, arr_en, out_we;
    logic [2:0]  inst_addr;
    logic [4:0]  inst_q;
    logic [4:0]  cur_inst;
    logic [7:0]  rd_col;
    logic [3:0]  res_sel;
    logic [6:0]  out_addr;
`ifdef SYSTOLIC_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    logic [4:0]  imem [8];

    int n_cmp = 0;
    int n_fail = 0;

    int exp_rd[$], exp_wr[$], exp_cur[$];
    int obs_rd[$], obs_en[$], obs_wr[$], obs_cur[$];
    int exp_done, obs_done, obs_done_n, obs_busy, obs_post_busy, obs_cur_done;
    int obs_perf;
    bit exp_err, obs_err;

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) inst_q <= imem[inst_addr];

    systolic_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .busy        (busy),
        .err_ovf     (err_ovf),
        .inst_addr   (inst_addr),
        .inst_data   (inst_q),
        .cur_inst    (cur_inst),
        .rd_en       (rd_en),
        .rd_col      (rd_col),
        .arr_clr     (arr_clr),
        .arr_en      (arr_en),
        .res_sel     (res_sel),
        .out_addr    (out_addr),
`ifdef SYSTOLIC_PERF_CNT_EN
        .perf_cycles (perf_cycles),
`endif
        .out_we      (out_we)
    );

    function automatic logic [33:0] all_outs();
        return {ap_done, busy, err_ovf, inst_addr, cur_inst, rd_en, rd_col,
                arr_clr, arr_en, res_sel, out_addr, out_we};
    endfunction

    // Program-level reference: what a program must produce, cycle counts
    // derived from the phase lengths of each instruction.
    task automatic model_prog();
        int col, span, k;
        exp_rd.delete(); exp_wr.delete(); exp_cur.delete();
        col = 0; exp_done = 3; exp_err = 0;
        for (int i = 0; i < 8; i++) begin
            k = int'(imem[i]);
            if (k == 0) break;
            span = k + 6 + ((i != 0) ? 1 : 0);
            if (col + span > 256) begin exp_err = 1; break; end
            exp_cur.push_back(k);
            for (int j = 0; j < span; j++) exp_rd.push_back((col + j) % 256);
            for (int e = 0; e < 16; e++) exp_wr.push_back(e * 256 + i * 16 + e);
            exp_done += 1 + 1 + 1 + span + 1 + 2 + 16 + 1;
            col += span;
        end
    endtask

    // Starts the program and records everything the DUT emits until done.
    task automatic run_prog(input int restart_at);
        int c, prev_rd;
        bit prev_en;
        obs_rd.delete(); obs_en.delete(); obs_wr.delete(); obs_cur.delete();
        obs_done = -1; obs_done_n = 0; obs_busy = 0; obs_post_busy = 0;
        obs_cur_done = -1; obs_err = 0; obs_perf = -1;
        prev_en = 0; prev_rd = 0;
        @(negedge clk);
        ap_start = 1'b1;
        c = 0;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            ap_start = (c == restart_at);
            if (busy) begin
                if (obs_done < 0) obs_busy++;
                else obs_post_busy++;
            end
            if (arr_en) obs_en.push_back(prev_en ? prev_rd : -1);
            prev_en = rd_en;
            prev_rd = int'(rd_col);
            if (rd_en) obs_rd.push_back(int'(rd_col));
            if (out_we) obs_wr.push_back(int'(res_sel) * 256 + int'(out_addr));
            if (arr_clr) obs_cur.push_back(int'(cur_inst));
            if (ap_done) begin
                obs_done_n++;
                if (obs_done < 0) begin
                    obs_done = c; obs_err = err_ovf; obs_cur_done = int'(cur_inst);
                end
            end
`ifdef SYSTOLIC_PERF_CNT_EN
            if (obs_done >= 0 && c == obs_done + 2) obs_perf = int'(perf_cycles);
`endif
            if (obs_done >= 0 && c >= obs_done + 4) break;
        end
        ap_start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL idle_outputs: got %h want 0", all_outs());
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) imem[i] = '0;
        imem[0] = 5'd4;
        model_prog();
        run_prog(0);
        n_cmp++;
        if (obs_done !== exp_done) begin
            n_fail++; $display("FAIL single done_cycle: got %0d want %0d", obs_done, exp_done);
        end
        n_cmp++;
        if (obs_rd.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL single rd_count: got %0d want %0d", obs_rd.size(), exp_rd.size());
        end else for (int i = 0; i < exp_rd.size(); i++) if (obs_rd[i] !== exp_rd[i]) begin
            n_fail++; $display("FAIL single rd_col[%0d]: got %0d want %0d", i, obs_rd[i], exp_rd[i]); break;
        end
        n_cmp++;
        if (obs_en.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL single arr_en_count: got %0d want %0d", obs_en.size(), exp_rd.size());
        end else for (int i = 0; i < exp_rd.size(); i++) if (obs_en[i] !== exp_rd[i]) begin
            n_fail++; $display("FAIL single arr_en[%0d]: got %0d want %0d", i, obs_en[i], exp_rd[i]); break;
        end
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL single wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end else for (int i = 0; i < exp_wr.size(); i++) if (obs_wr[i] !== exp_wr[i]) begin
            n_fail++; $display("FAIL single wr[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]); break;
        end
        n_cmp++;
        if (obs_busy !== exp_done) begin
            n_fail++; $display("FAIL single busy_cycles: got %0d want %0d", obs_busy, exp_done);
        end
`ifdef SYSTOLIC_PERF_CNT_EN
        n_cmp++;
        if (obs_perf !== exp_done - 1) begin
            n_fail++; $display("FAIL single perf_cycles: got %0d want %0d", obs_perf, exp_done - 1);
        end
`endif
    endtask

    task automatic test_multi();
        for (int i = 0; i < 8; i++) imem[i] = '0;
        imem[0] = 5'd2; imem[1] = 5'd3; imem[2] = 5'd1;
        model_prog();
        run_prog(0);
        n_cmp++;
        if (obs_rd.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL multi rd_count: got %0d want %0d", obs_rd.size(), exp_rd.size());
        end else for (int i = 0; i < exp_rd.size(); i++) if (obs_rd[i] !== exp_rd[i]) begin
            n_fail++; $display("FAIL multi rd_col[%0d]: got %0d want %0d", i, obs_rd[i], exp_rd[i]); break;
        end
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL multi wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end else for (int i = 0; i < exp_wr.size(); i++) if (obs_wr[i] !== exp_wr[i]) begin
            n_fail++; $display("FAIL multi wr[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]); break;
        end
        n_cmp++;
        if (obs_cur.size() != exp_cur.size()) begin
            n_fail++; $display("FAIL multi cur_count: got %0d want %0d", obs_cur.size(), exp_cur.size());
        end else for (int i = 0; i < exp_cur.size(); i++) if (obs_cur[i] !== exp_cur[i]) begin
            n_fail++; $display("FAIL multi cur_inst[%0d]: got %0d want %0d", i, obs_cur[i], exp_cur[i]); break;
        end
        n_cmp++;
        if (obs_done !== exp_done || obs_done_n !== 1) begin
            n_fail++; $display("FAIL multi done: got cycle %0d x%0d want cycle %0d x1", obs_done, obs_done_n, exp_done);
        end
        n_cmp++;
        if (obs_cur_done !== 0) begin
            n_fail++; $display("FAIL multi cur_at_done: got %0d want 0", obs_cur_done);
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 8; i++) imem[i] = '0;
        model_prog();
        run_prog(2);
        n_cmp++;
        if (obs_rd.size() != 0 || obs_wr.size() != 0) begin
            n_fail++; $display("FAIL empty activity: got rd %0d wr %0d want 0 0", obs_rd.size(), obs_wr.size());
        end
        n_cmp++;
        if (obs_done !== exp_done || obs_done_n !== 1) begin
            n_fail++; $display("FAIL empty done: got cycle %0d x%0d want cycle %0d x1", obs_done, obs_done_n, exp_done);
        end
        n_cmp++;
        if (obs_post_busy !== 0) begin
            n_fail++; $display("FAIL empty restart_ignored: got %0d busy cycles after done want 0", obs_post_busy);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) imem[i] = 5'd31;
        model_prog();
        run_prog(0);
        n_cmp++;
        if (obs_err !== exp_err) begin
            n_fail++; $display("FAIL ovf err_ovf: got %0d want %0d", obs_err, exp_err);
        end
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL ovf wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        end else for (int i = 0; i < exp_wr.size(); i++) if (obs_wr[i] !== exp_wr[i]) begin
            n_fail++; $display("FAIL ovf wr[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]); break;
        end
        n_cmp++;
        if (obs_done !== exp_done || obs_done_n !== 1) begin
            n_fail++; $display("FAIL ovf done: got cycle %0d x%0d want cycle %0d x1", obs_done, obs_done_n, exp_done);
        end
        n_cmp++;
        if (err_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf err_sticky: got %0d want 1", err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int w, dn;
        for (int i = 0; i < 8; i++) imem[i] = 5'd31;
        @(negedge clk); ap_start = 1'b1;
        @(negedge clk); ap_start = 1'b0;
        w = 0;
        while (!rd_en && w < 200) begin @(negedge clk); w++; end
        n_cmp++;
        if (rd_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid reach_stream: got rd_en %0d want 1", rd_en);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL rstmid async_outputs: got %h want 0", all_outs());
        end
        dn = 0;
        repeat (2) begin @(negedge clk); if (ap_done) dn++; end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); if (ap_done || busy) dn++; end
        n_cmp++;
        if (dn !== 0) begin
            n_fail++; $display("FAIL rstmid no_done: got %0d active cycles want 0", dn);
        end
        for (int i = 0; i < 8; i++) imem[i] = '0;
        imem[0] = 5'd5; imem[1] = 5'd2;
        model_prog();
        run_prog(0);
        n_cmp++;
        if (obs_rd.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL rstmid rd_count: got %0d want %0d", obs_rd.size(), exp_rd.size());
        end else for (int i = 0; i < exp_rd.size(); i++) if (obs_rd[i] !== exp_rd[i]) begin
            n_fail++; $display("FAIL rstmid rd_col[%0d]: got %0d want %0d", i, obs_rd[i], exp_rd[i]); break;
        end
        n_cmp++;
        if (obs_done !== exp_done || obs_err !== exp_err) begin
            n_fail++; $display("FAIL rstmid done: got cycle %0d err %0d want cycle %0d err %0d",
                               obs_done, obs_err, exp_done, exp_err);
        end
    endtask

    task automatic test_random();
        int ra;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 8; i++)
                imem[i] = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            model_prog();
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, exp_done)) : 0;
            run_prog(ra);
            n_cmp++;
            if (obs_rd.size() != exp_rd.size()) begin
                n_fail++; $display("FAIL rand%0d rd_count: got %0d want %0d", t, obs_rd.size(), exp_rd.size());
            end else for (int i = 0; i < exp_rd.size(); i++) if (obs_rd[i] !== exp_rd[i] || obs_en[i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL rand%0d rd/en[%0d]: got %0d/%0d want %0d", t, i, obs_rd[i], obs_en[i], exp_rd[i]); break;
            end
            n_cmp++;
            if (obs_wr.size() != exp_wr.size()) begin
                n_fail++; $display("FAIL rand%0d wr_count: got %0d want %0d", t, obs_wr.size(), exp_wr.size());
            end else for (int i = 0; i < exp_wr.size(); i++) if (obs_wr[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL rand%0d wr[%0d]: got %h want %h", t, i, obs_wr[i], exp_wr[i]); break;
            end
            n_cmp++;
            if (obs_cur.size() != exp_cur.size()) begin
                n_fail++; $display("FAIL rand%0d cur_count: got %0d want %0d", t, obs_cur.size(), exp_cur.size());
            end else for (int i = 0; i < exp_cur.size(); i++) if (obs_cur[i] !== exp_cur[i]) begin
                n_fail++; $display("FAIL rand%0d cur_inst[%0d]: got %0d want %0d", t, i, obs_cur[i], exp_cur[i]); break;
            end
            n_cmp++;
            if (obs_done !== exp_done || obs_done_n !== 1 || obs_err !== exp_err || obs_post_busy !== 0) begin
                n_fail++; $display("FAIL rand%0d done: got cycle %0d x%0d err %0d post %0d want cycle %0d x1 err %0d post 0",
                                   t, obs_done, obs_done_n, obs_err, obs_post_busy, exp_done, exp_err);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) imem[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
